instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/rvcpu_pkg.sv | 26 ++
 rtl/fetch_fifo.sv | 70 +++++++
 rtl/instr_fetch.sv | 109 ++++++++++
 3 files changed

// File: rtl/rvcpu_pkg.sv
// Shared CPU-wide constants, the fetch buffer entry layout and PC helpers.
package rvcpu_pkg;

  localparam int XLEN   = 32;
  localparam int INST_W = 32;

  localparam logic [XLEN-1:0]   RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [INST_W-1:0] NOP_INST         = 32'h0000_0013;

  // One buffered instruction: address tag in the upper half, word in the lower.
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] instr;
  } fetch_entry_t;

  // Sequential next word address; natural 32-bit wrap takes FFFF_FFFC to 0.
  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

  // Force word alignment on an externally supplied target address.
  function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Registered instruction buffer: DEPTH entries of {pc, instr}, with push,
// pop, flush and an occupancy count. The head reads as zero when empty.
module fetch_fifo
  import rvcpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [63:0]            push_data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic [63:0]            head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // Next-state: flush wins over everything; push+pop together keeps count.
  always_comb begin
    do_pop   = pop_i && (count_q != CW'(0));
    do_push  = push_i && ((count_q != CW'(DEPTH)) || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      else         wr_ptr_d = wr_ptr_q;
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      else         rd_ptr_d = rd_ptr_q;
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (!do_push && do_pop) count_d = count_q - CW'(1);
      else                         count_d = count_q;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only visible through head_o when non-empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = (count_q != CW'(0)) ? mem_q[rd_ptr_q] : 64'h0;
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues sequential word fetches under a credit
// limit, tags in-order responses with their PC into fetch_fifo, and handles
// redirects by flushing the buffer and discarding in-flight responses.
module instr_fetch
  import rvcpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUT + 1);

  logic          run_q;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [OW-1:0] out_q, out_d;
  logic [OW-1:0] disc_q, disc_d;
  logic [CW-1:0] count;
  logic [63:0]   head;
  logic [31:0]   credit_sum;
  logic          req_fire, rsp_keep, rsp_drop, push, pop;

  // Buffered entries plus in-flight requests must fit the buffer, so a
  // response can never arrive to a full buffer. run_q holds requests off
  // while reset is asserted.
  assign credit_sum     = 32'(count) + 32'(out_q);
  assign imem_req_valid = run_q && (32'(out_q) < 32'(MAX_OUT)) &&
                          (credit_sum < 32'(DEPTH)) && !redirect_valid;
  assign imem_req_addr  = fetch_pc_q;

  // Next-state for fetch/response PCs and the outstanding/discard counters.
  always_comb begin
    req_fire   = imem_req_valid && imem_req_ready;
    rsp_drop   = imem_rsp_valid && (disc_q != OW'(0));
    rsp_keep   = imem_rsp_valid && (disc_q == OW'(0));
    push       = rsp_keep && !redirect_valid;
    pop        = inst_valid && inst_ready && !redirect_valid;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    out_d      = out_q;
    disc_d     = disc_q;
    if (req_fire && !imem_rsp_valid)      out_d = out_q + OW'(1);
    else if (!req_fire && imem_rsp_valid) out_d = out_q - OW'(1);
    else                                  out_d = out_q;
    if (redirect_valid) begin
      // No request can fire on a redirect cycle, so every request still
      // outstanding afterwards belongs to the abandoned path.
      fetch_pc_d = pc_align(redirect_pc);
      rsp_pc_d   = pc_align(redirect_pc);
      disc_d     = out_d;
    end else begin
      if (req_fire) fetch_pc_d = pc_next(fetch_pc_q);
      else          fetch_pc_d = fetch_pc_q;
      if (rsp_keep) rsp_pc_d = pc_next(rsp_pc_q);
      else          rsp_pc_d = rsp_pc_q;
      if (rsp_drop) disc_d = disc_q - OW'(1);
      else          disc_d = disc_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q      <= 1'b0;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_q      <= '0;
      disc_q     <= '0;
    end else begin
      run_q      <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i ({rsp_pc_q, imem_rsp_data}),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .head_o      (head),
    .count_o     (count)
  );

  assign inst_valid = (count != CW'(0));
  assign inst_pc    = head[63:32];
  assign inst_data  = head[31:0];

endmodule
